// File: rtl/param_voting_machine.sv
// Parametrised ballot counter: qualifies one-hot presses from debounced buttons,
// enforces a post-vote lockout and release, and tracks totals and the leader.
module param_voting_machine #(
  parameter int N_CAND   = 6,
  parameter int CNT_W    = 10,
  parameter int LOCK_CYC = 4,
  localparam int IDX_W   = ($clog2(N_CAND) > 1) ? $clog2(N_CAND) : 1,
  localparam int TOT_W   = CNT_W + IDX_W
) (
  input  logic                    CLK,
  input  logic                    CLEAR,
  input  logic                    BALLOT_EN,
  input  logic [N_CAND-1:0]       VOTE_BTN,
  output logic [N_CAND*CNT_W-1:0] VOTES_FLAT,
  output logic [TOT_W-1:0]        TOTAL,
  output logic [IDX_W-1:0]        LEADER,
  output logic                    TIE,
  output logic                    VOTE_ACK,
  output logic                    INVALID,
  output logic                    BUSY,
  output logic                    SAT
);

  typedef enum logic [1:0] {CLOSED, READY, LOCK, WAIT_REL} state_t;

  state_t            state, next_state;
  logic [7:0]        lock_cnt, lock_next;
  logic              vote_accept, vote_invalid;
  logic              btn_onehot, btn_multi;
  logic [CNT_W-1:0]  counts [N_CAND];
  logic [CNT_W-1:0]  best_val;

  assign btn_onehot = $onehot(VOTE_BTN);
  assign btn_multi  = (VOTE_BTN != '0) && !btn_onehot;

  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      state    <= CLOSED;
      lock_cnt <= '0;
    end else begin
      state    <= next_state;
      lock_cnt <= lock_next;
    end
  end

  // Losing BALLOT_EN beats any press seen on the same edge.
  always_comb begin
    next_state   = state;
    lock_next    = lock_cnt;
    vote_accept  = 1'b0;
    vote_invalid = 1'b0;
    case (state)
      CLOSED: begin
        if (BALLOT_EN) next_state = WAIT_REL;
      end
      READY: begin
        if (!BALLOT_EN) begin
          next_state = CLOSED;
        end else if (btn_onehot) begin
          vote_accept = 1'b1;
          lock_next   = 8'(LOCK_CYC);
          next_state  = LOCK;
        end else if (btn_multi) begin
          vote_invalid = 1'b1;
          lock_next    = 8'(LOCK_CYC);
          next_state   = LOCK;
        end
      end
      LOCK: begin
        if (!BALLOT_EN) begin
          next_state = CLOSED;
        end else begin
          lock_next = lock_cnt - 8'd1;
          if (lock_cnt <= 8'd1) next_state = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!BALLOT_EN) next_state = CLOSED;
        else if (VOTE_BTN == '0) next_state = READY;
      end
      default: next_state = CLOSED;
    endcase
  end

  assign BUSY = (state == LOCK) || (state == WAIT_REL);

  // Only one button can be set on an accepted vote, so TOTAL sees one increment.
  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      for (int i = 0; i < N_CAND; i++) counts[i] <= '0;
      TOTAL    <= '0;
      SAT      <= 1'b0;
      VOTE_ACK <= 1'b0;
      INVALID  <= 1'b0;
    end else begin
      VOTE_ACK <= vote_accept;
      INVALID  <= vote_invalid;
      for (int i = 0; i < N_CAND; i++) begin
        if (vote_accept && VOTE_BTN[i]) begin
          if (counts[i] == {CNT_W{1'b1}}) begin
            SAT <= 1'b1;
          end else begin
            counts[i] <= counts[i] + 1'b1;
            TOTAL     <= TOTAL + 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < N_CAND; g++) begin : g_flat
    assign VOTES_FLAT[g*CNT_W +: CNT_W] = counts[g];
  end

  // NOTA is the top index and is left out of the race.
  always_comb begin
    best_val = counts[0];
    LEADER   = '0;
    TIE      = 1'b0;
    for (int i = 1; i < N_CAND - 1; i++) begin
      if (counts[i] > best_val) begin
        best_val = counts[i];
        LEADER   = IDX_W'(i);
        TIE      = 1'b0;
      end else if (counts[i] == best_val) begin
        TIE = 1'b1;
      end
    end
    if (best_val == '0) TIE = 1'b0;
  end

endmodule

// File: tb/tb_param_voting_machine.sv
// Self-checking bench: directed scenarios then random button traffic, all
// compared each cycle against a behavioural ballot model.
module tb_param_voting_machine;

  localparam int N     = 6;
  localparam int W     = 3;
  localparam int L     = 4;
  localparam int IDX_W = 3;
  localparam int TOT_W = W + IDX_W;
  localparam int MAXC  = (1 << W) - 1;

  logic             CLK = 1'b0;
  logic             CLEAR = 1'b0;
  logic             BALLOT_EN = 1'b0;
  logic [N-1:0]     VOTE_BTN = '0;
  logic [N*W-1:0]   VOTES_FLAT;
  logic [TOT_W-1:0] TOTAL;
  logic [IDX_W-1:0] LEADER;
  logic             TIE, VOTE_ACK, INVALID, BUSY, SAT;

  int checks = 0;
  int fails  = 0;

  // Model: ballot counts plus poll/cooldown/release bookkeeping.
  int m_cnt [N];
  int m_total, m_cool;
  bit m_sat, m_ack, m_inv, m_open, m_armed;

  param_voting_machine #(.N_CAND(N), .CNT_W(W), .LOCK_CYC(L)) dut (
    .CLK(CLK), .CLEAR(CLEAR), .BALLOT_EN(BALLOT_EN), .VOTE_BTN(VOTE_BTN),
    .VOTES_FLAT(VOTES_FLAT), .TOTAL(TOTAL), .LEADER(LEADER), .TIE(TIE),
    .VOTE_ACK(VOTE_ACK), .INVALID(INVALID), .BUSY(BUSY), .SAT(SAT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelStep(input bit clr, input bit en, input logic [N-1:0] btn);
    int ones, idx;
    if (clr) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_total = 0; m_sat = 0; m_ack = 0; m_inv = 0;
      m_open = 0; m_cool = 0; m_armed = 0;
      return;
    end
    m_ack = 0; m_inv = 0;
    ones = $countones(btn);
    idx = 0;
    for (int i = 0; i < N; i++) if (btn[i]) idx = i;
    if (!m_open) begin
      if (en) begin m_open = 1; m_armed = 0; m_cool = 0; end
    end else if (!en) begin
      m_open = 0;
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (!m_armed) begin
      if (ones == 0) m_armed = 1;
    end else if (ones == 1) begin
      if (m_cnt[idx] == MAXC) m_sat = 1;
      else begin m_cnt[idx]++; m_total++; end
      m_ack = 1; m_cool = L; m_armed = 0;
    end else if (ones > 1) begin
      m_inv = 1; m_cool = L; m_armed = 0;
    end
  endtask

  task automatic checkAll();
    logic [N*W-1:0] flat;
    int maxv, lead, nmax;
    flat = '0;
    for (int i = 0; i < N; i++) flat[i*W +: W] = W'(m_cnt[i]);
    maxv = 0;
    for (int i = 0; i < N - 1; i++) if (m_cnt[i] > maxv) maxv = m_cnt[i];
    lead = -1; nmax = 0;
    for (int i = 0; i < N - 1; i++)
      if (m_cnt[i] == maxv) begin nmax++; if (lead < 0) lead = i; end
    checkOutput("votes",   32'(VOTES_FLAT), 32'(flat));
    checkOutput("total",   32'(TOTAL),      32'(m_total));
    checkOutput("leader",  32'(LEADER),     32'(lead));
    checkOutput("tie",     32'(TIE),        32'((maxv > 0) && (nmax >= 2)));
    checkOutput("ack",     32'(VOTE_ACK),   32'(m_ack));
    checkOutput("invalid", 32'(INVALID),    32'(m_inv));
    checkOutput("busy",    32'(BUSY),       32'(m_open && (m_cool > 0 || !m_armed)));
    checkOutput("sat",     32'(SAT),        32'(m_sat));
  endtask

  task automatic applyStimulus(input bit clr, input bit en, input logic [N-1:0] btn);
    CLEAR = clr; BALLOT_EN = en; VOTE_BTN = btn;
    @(posedge CLK);
    modelStep(clr, en, btn);
    #1;
    checkAll();
  endtask

  task automatic pressOnce(input logic [N-1:0] btn);
    applyStimulus(0, 1, btn);
    repeat (L + 1) applyStimulus(0, 1, '0);
  endtask

  task automatic openPoll();
    applyStimulus(1, 0, '0);
    applyStimulus(0, 1, '0);
    applyStimulus(0, 1, '0);
  endtask

  initial begin
    logic [N-1:0] btn;
    int hold, r;
    bit en, clr;

    openPoll();
    for (int i = 0; i < N; i++) pressOnce(N'(1 << i));
    checkOutput("six_total", 32'(TOTAL), 32'd6);
    checkOutput("six_tie",   32'(TIE),   32'd1);
    checkOutput("six_lead",  32'(LEADER), 32'd0);

    repeat (20) applyStimulus(0, 1, N'(4));
    applyStimulus(0, 1, '0);
    pressOnce(N'(4));
    checkOutput("hold_cnt2", 32'(VOTES_FLAT[2*W +: W]), 32'd3);

    pressOnce(N'('b1010));
    pressOnce(N'('b1000));
    checkOutput("multi_cnt3", 32'(VOTES_FLAT[3*W +: W]), 32'd2);

    openPoll();
    repeat (5) pressOnce(N'(1 << (N - 1)));
    checkOutput("nota_total", 32'(TOTAL), 32'd5);
    checkOutput("nota_tie",   32'(TIE),   32'd0);
    checkOutput("nota_lead",  32'(LEADER), 32'd0);

    openPoll();
    repeat (9) pressOnce(N'(1));
    checkOutput("sat_cnt0",  32'(VOTES_FLAT[0 +: W]), 32'd7);
    checkOutput("sat_total", 32'(TOTAL), 32'd7);
    checkOutput("sat_flag",  32'(SAT),   32'd1);

    openPoll();
    applyStimulus(0, 0, N'(2));
    checkOutput("drop_total", 32'(TOTAL), 32'd0);
    repeat (4) applyStimulus(0, 1, N'(2));
    checkOutput("held_total", 32'(TOTAL), 32'd0);
    applyStimulus(0, 1, '0);
    pressOnce(N'(2));
    checkOutput("repress_total", 32'(TOTAL), 32'd1);
    applyStimulus(0, 1, N'(1));
    applyStimulus(0, 1, '0);
    applyStimulus(1, 1, '0);
    checkOutput("clr_busy", 32'(BUSY), 32'd0);

    btn = '0; hold = 0; en = 1;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        r = $urandom_range(0, 9);
        if (r < 5) btn = '0;
        else if (r < 8) btn = N'(1 << $urandom_range(0, N - 1));
        else if (r == 8) btn = N'($urandom);
        hold = $urandom_range(1, 6);
      end
      hold--;
      if ($urandom_range(0, 99) < 3) en = ~en;
      clr = ($urandom_range(0, 999) < 3);
      applyStimulus(clr, en, btn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
